// File: rtl/display_bcd_driver.sv
// display_bcd_driver
//   Captures a 16-bit unsigned value on displayWrite, converts it to five BCD
//   digits with a sequential double-dabble engine (one iteration per clock),
//   and scans the result onto a 5-digit common-anode 7-segment display.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        synchronous, active-low reset
//   displayWrite request to display dataIn; only sampled while idle
//   dataIn       16-bit unsigned value to display
//   busy         high while a conversion is in progress
//   bcdOut       last completed result, digit 4 in [19:16] .. digit 0 in [3:0]
//   digitSel     active-low one-hot digit enable, bit 0 = least significant
//   segments     active-low segments {g,f,e,d,c,b,a}
module display_bcd_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        displayWrite,
  input  logic [15:0] dataIn,
  output logic        busy,
  output logic [19:0] bcdOut,
  output logic [4:0]  digitSel,
  output logic [6:0]  segments
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPD
  } state_t;

  state_t        state;
  logic [35:0]   shreg;
  logic [3:0]    iter;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;

  // One double-dabble iteration: correct every BCD nibble that would
  // overflow past 9 on doubling, then shift the whole register left.
  function automatic logic [35:0] dd_step(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int unsigned i = 0; i < 5; i++) begin
      if (t[16 + 4*i +: 4] >= 4'd5)
        t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      iter   <= '0;
      bcdOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (displayWrite) begin
            shreg <= {20'b0, dataIn};
            iter  <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          shreg <= dd_step(shreg);
          iter  <= iter + 4'd1;
          if (iter == 4'd15)
            state <= UPD;
        end
        UPD: begin
          bcdOut <= shreg[35:16];
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Free-running digit scan
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign digitSel = ~(5'b00001 << idx);

  // Segment decode with leading-zero blanking: a digit above 0 is dark when
  // it and all higher digits are zero, i.e. bcdOut shifted down to it is zero.
  logic [19:0] shifted;
  logic [3:0]  nib;
  logic        blank;

  always_comb begin
    shifted = bcdOut >> {idx, 2'b00};
    nib     = shifted[3:0];
    blank   = (idx != 3'd0) && (shifted == '0);
    segments = 7'b1111111;
    if (!blank) begin
      case (nib)
        4'd0: segments = 7'b1000000;
        4'd1: segments = 7'b1111001;
        4'd2: segments = 7'b0100100;
        4'd3: segments = 7'b0110000;
        4'd4: segments = 7'b0011001;
        4'd5: segments = 7'b0010010;
        4'd6: segments = 7'b0000010;
        4'd7: segments = 7'b1111000;
        4'd8: segments = 7'b0000000;
        4'd9: segments = 7'b0010000;
        default: segments = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_display_bcd_driver.sv
module tb_display_bcd_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        displayWrite;
  logic [15:0] dataIn;
  logic        busy;
  logic [19:0] bcdOut;
  logic [4:0]  digitSel;
  logic [6:0]  segments;

  int passed = 0;
  int total  = 0;

  logic [19:0] sb[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  display_bcd_driver #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .displayWrite(displayWrite),
    .dataIn      (dataIn),
    .busy        (busy),
    .bcdOut      (bcdOut),
    .digitSel    (digitSel),
    .segments    (segments)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Capture a value, measure busy length, then compare against the scoreboard.
  // inject > 0 re-pulses displayWrite with a different dataIn at that busy cycle.
  task automatic convert(input logic [15:0] v, input int inject);
    int cnt;
    logic [19:0] exp;
    dataIn = v;
    displayWrite = 1'b1;
    sb.push_back(to_bcd(v));
    @(negedge clk);
    displayWrite = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == inject) begin
        dataIn = 16'd7;
        displayWrite = 1'b1;
      end else begin
        displayWrite = 1'b0;
      end
      @(negedge clk);
    end
    displayWrite = 1'b0;
    chk("busy_len", cnt, 17);
    if (sb.size() == 0) begin
      chk("sb_empty", sb.size(), 1);
    end else begin
      exp = sb.pop_front();
      chk("bcdOut", bcdOut, exp);
    end
  endtask

  task automatic check_scan(input logic [19:0] bcd);
    logic [4:0]  prev;
    logic [4:0]  exp_sel;
    logic [6:0]  exp_seg;
    logic [19:0] sh;
    int n;
    prev = digitSel;
    n = 0;
    @(negedge clk);
    while (!(digitSel == 5'b11110 && prev == 5'b01111) && n < 40) begin
      prev = digitSel;
      n++;
      @(negedge clk);
    end
    chk("scan_sync", (n < 40) ? 1 : 0, 1);
    for (int s = 0; s < 5; s++) begin
      exp_sel = ~(5'(1) << s);
      sh = bcd >> (4 * s);
      if (s > 0 && sh == 20'd0)
        exp_seg = 7'b1111111;
      else if (sh[3:0] > 4'd9)
        exp_seg = 7'b1111111;
      else
        exp_seg = seg_tab[sh[3:0]];
      for (int c = 0; c < 4; c++) begin
        chk("digitSel", digitSel, exp_sel);
        chk("segments", segments, exp_seg);
        @(negedge clk);
      end
    end
    chk("scan_wrap", digitSel, 5'b11110);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    displayWrite = 1'b0;
    dataIn = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcdOut, 0);
    chk("rst_sel", digitSel, 5'b11110);
    chk("rst_seg", segments, 7'b1000000);

    convert(16'd1234, 0);
    check_scan(20'h01234);
    convert(16'd65535, 0);
    chk("max", bcdOut, 20'h65535);
    check_scan(20'h65535);
    convert(16'd0, 0);
    check_scan(20'h00000);
    convert(16'd9, 0);
    convert(16'd17890, 0);
    check_scan(20'h17890);
    convert(16'd42, 0);
    check_scan(20'h00042);
    convert(16'd60, 0);
    check_scan(20'h00060);

    // write while busy is dropped, with no follow-up conversion
    convert(16'd1234, 5);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    chk("no_requeue", n, 0);
    chk("busy_ignored", bcdOut, 20'h01234);

    // reset in the middle of a conversion
    dataIn = 16'd500;
    displayWrite = 1'b1;
    @(negedge clk);
    displayWrite = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_bcd", bcdOut, 0);
    chk("mid_sel", digitSel, 5'b11110);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("post_bcd", bcdOut, 0);
    chk("post_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/display_bcd_driver.md
Name: display_bcd_driver

Overview:
- Consumer end of the control unit's `displayWrite` strobe.
- Captures a 16-bit unsigned value from the datapath and converts it to 5-digit BCD with a sequential double-dabble (shift-add-3) engine.
- Time-multiplexes the result onto a 5-digit common-anode 7-segment display.
- Sits between the datapath result bus and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays lit before the scan advances (minimum 2; benches use 4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
displayWrite  input  1  request to display dataIn; sampled only in IDLE
dataIn  input  16  unsigned value to display
busy  output  1  high while a conversion is in progress
bcdOut  output  20  last completed BCD result, digit 4 in [19:16] down to digit 0 in [3:0]
digitSel  output  5  active-low one-hot digit enable, bit 0 = least significant digit
segments  output  7  active-low segments, ordered {g,f,e,d,c,b,a}

Behaviour:
- One clock; reset is synchronous and active-low.
- On any clk edge with reset=0:
  - state=IDLE, busy=0, bcdOut=0, iteration counter=0, scan counter=0, digit index=0.
  - Outputs then show digitSel=5'b11110 and segments=7'b1000000 (digit "0").
  - Reset mid-conversion aborts it; bcdOut is cleared, not updated.
- FSM states: IDLE, CONV, UPD.
- IDLE:
  - If displayWrite=1: load shift register {20'b0, dataIn}, clear the iteration counter, go to CONV.
  - Otherwise stay in IDLE.
- CONV: one iteration per cycle.
  - Each 4-bit BCD nibble >= 5 gets +3.
  - Then the whole 36-bit register shifts left by 1.
  - After the 16th iteration (counter == 15), go to UPD.
- UPD: bcdOut <= shift register [35:16], go to IDLE.
- busy = (state != IDLE), registered through the state.
- Latency: with the capture edge as edge 0:
  - busy is high after edges 0..16 (17 cycles).
  - bcdOut shows the new value after edge 17.
  - A new capture is possible at edge 18.
- displayWrite while busy is ignored, with no queuing.
  - Level-held displayWrite (the control unit holds it high in every state) re-captures dataIn every 18 cycles.
  - This is required behaviour.
- dataIn is sampled only at the capture edge; changes during CONV have no effect.
- Scan:
  - The free-running scan counter counts 0..SCAN_DIV-1 and wraps to 0.
  - On each wrap the digit index advances 0→1→2→3→4→0.
  - digitSel = ~(5'b00001 << index).
- Segment decode is combinational from bcdOut and the digit index:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble > 9 gives 1111111 (unreachable by construction).
- Leading-zero blanking:
  - Digit k>0 shows 1111111 when it and every higher digit are zero.
  - Digit 0 is never blanked.
- Scanning runs independently of conversion. bcdOut changes take effect on the currently lit digit in the same cycle, with no glitch suppression required.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → busy=0, bcdOut=20'h00000, digitSel=5'b11110, segments=7'b1000000.
- Basic conversion: dataIn=16'd1234, displayWrite pulsed 1 cycle in IDLE → busy=1 for exactly 17 cycles, then bcdOut=20'h01234.
- Boundaries:
  - 16'd65535 → bcdOut=20'h65535.
  - 16'd0 → bcdOut=20'h00000.
  - 16'd9 → bcdOut=20'h00009.
- Busy write ignored: start with 16'd1234; at busy cycle 5 pulse displayWrite with dataIn=16'd7 → bcdOut=20'h01234, busy falls on schedule, no second conversion.
- Scan and blanking: SCAN_DIV=4, bcdOut=20'h00042 → 4-cycle slots in this order:
  - digitSel=11110 with segments=0100100
  - digitSel=11101 with segments=0011001
  - digitSel=11011, 10111 and 01111, each with segments=1111111
  - then back to 11110.
- Reset mid-operation: dataIn=16'd500, assert reset=0 at conversion cycle 8 → next edge busy=0, bcdOut=0; after release with displayWrite=0, bcdOut stays 0.
